// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32 shift-add / restoring shift-subtract
// steps over one shared 33-bit adder, fixed 34-cycle start-to-done latency.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [4:0]        cnt;

  logic [2:0]        f_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  logic              is_mul;
  logic              signed_a;
  logic              signed_b;
  logic [XLEN:0]     add_x;
  logic [XLEN:0]     add_y;
  logic              sub;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   fix_val;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? ((~v) + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? ((~v) + (2*XLEN)'(1)) : v;
  endfunction

  assign is_mul   = ~f_q[2];
  assign signed_a = is_mul ? (f_q[1:0] == 2'b01 || f_q[1:0] == 2'b10) : ~f_q[0];
  assign signed_b = is_mul ? (f_q[1:0] == 2'b01) : ~f_q[0];

  // One 33-bit adder: multiply adds the multiplicand into the upper half,
  // divide subtracts the divisor from the left-shifted remainder (bit 32 = borrow).
  always_comb begin
    add_x = is_mul ? {1'b0, acc[2*XLEN-1:XLEN]} : acc[2*XLEN-1:XLEN-1];
    add_y = {1'b0, opnd};
    sub   = ~is_mul;
    sum   = add_x + (sub ? ~add_y : add_y) + {{XLEN{1'b0}}, sub};
    if (is_mul) begin
      acc_step = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    end else begin
      acc_step = sum[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                           : {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    prod     = cond_neg_wide(acc, sa ^ sb);
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    div_zero = (b_q == '0);
    div_ovf  = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    fix_val  = '0;
    case (f_q)
      3'b000:  fix_val = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_val = prod[2*XLEN-1:XLEN];
      3'b100:  fix_val = div_zero ? '1 :
                         div_ovf  ? {1'b1, {(XLEN-1){1'b0}}} : cond_neg(quo, sa ^ sb);
      3'b101:  fix_val = div_zero ? '1 : quo;
      3'b110:  fix_val = div_zero ? a_q : div_ovf ? '0 : cond_neg(rem, sa);
      default: fix_val = div_zero ? a_q : rem;
    endcase
  end

  // Operand and datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !flush) begin
      f_q <= funct3;
      a_q <= op_a;
      b_q <= op_b;
    end
    if (state == PREP) begin
      sa   <= signed_a & a_q[XLEN-1];
      sb   <= signed_b & b_q[XLEN-1];
      opnd <= is_mul ? cond_neg(a_q, signed_a & a_q[XLEN-1])
                     : cond_neg(b_q, signed_b & b_q[XLEN-1]);
      acc  <= {{XLEN{1'b0}}, is_mul ? cond_neg(b_q, signed_b & b_q[XLEN-1])
                                    : cond_neg(a_q, signed_a & a_q[XLEN-1])};
    end
    if (state == CALC) begin
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (state != IDLE && flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state <= PREP;
            busy  <= 1'b1;
          end
        end
        PREP: begin
          state <= CALC;
          cnt   <= '0;
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          result <= fix_val;
          done   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
